// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_pkg
// Purpose  : Shared defaults for the instruction prefetch queue.
// Revision : 1.0  initial release
// ============================================================================
package fetch_queue_pkg;

    localparam int              C_ADDR_W   = 16;
    localparam int              C_DATA_W   = 16;
    localparam int              C_DEPTH    = 4;
    localparam int              C_PC_INC   = 2;
    localparam logic [15:0]     C_RESET_PC = 16'h0000;

endpackage : fetch_queue_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Power-of-two FIFO with flush, exposing head entry and occupancy.
// Revision : 1.0  initial release
// ============================================================================
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int WIDTH = C_ADDR_W + C_DATA_W,
    parameter int DEPTH = C_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int C_PTR_W = $clog2(DEPTH);

    logic [C_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [C_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [C_PTR_W:0]   r_count_q,  w_count_d;
    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [WIDTH-1:0]   w_mem_d [DEPTH];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        w_mem_d    = r_mem_q;
        if (i_flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (i_push) begin
                w_mem_d[r_wr_ptr_q] = i_push_data;
                w_wr_ptr_d          = r_wr_ptr_q + 1'b1;
            end
            if (i_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   w_count_d = r_count_q + 1'b1;
                2'b01:   w_count_d = r_count_q - 1'b1;
                default: w_count_d = r_count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
            r_mem_q    <= '{default: '0};
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
            r_mem_q    <= w_mem_d;
        end
    end

    assign o_head  = r_mem_q[r_rd_ptr_q];
    assign o_count = r_count_q;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Credit-limited instruction prefetcher feeding decode via a FIFO.
// Revision : 1.0  initial release
// ============================================================================
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = C_ADDR_W,
    parameter int                DATA_W   = C_DATA_W,
    parameter int                DEPTH    = C_DEPTH,
    parameter int                PC_INC   = C_PC_INC,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(C_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nHaltSig,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] PC_B,
    input  logic              instr_ready,
    input  logic [DATA_W-1:0] imem_data,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] PC_curr,
    output logic [ADDR_W-1:0] PC_Next,
    output logic              halted
);

    localparam int C_CNT_W = $clog2(DEPTH) + 1;
    localparam int C_ENT_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0]  r_pc_q,       w_pc_d;
    logic               r_inflight_q, w_inflight_d;
    logic [ADDR_W-1:0]  r_infl_pc_q,  w_infl_pc_d;

    logic [C_CNT_W-1:0] w_count;
    logic [C_CNT_W-1:0] w_used;
    logic [C_ENT_W-1:0] w_head;
    logic               w_head_valid;
    logic               w_pop;
    logic               w_push;

    // Occupancy plus the outstanding request never exceeds DEPTH, so this sum fits.
    assign w_used       = w_count + C_CNT_W'(r_inflight_q);
    assign w_head_valid = rst & (w_count != '0);
    assign w_pop        = w_head_valid & instr_ready;
    assign w_push       = r_inflight_q & ~redirect;

    assign imem_en     = rst & nHaltSig & ~redirect & (w_used < C_CNT_W'(DEPTH));
    assign imem_addr   = r_pc_q;
    assign instr_valid = w_head_valid;
    assign instr       = w_head_valid ? w_head[DATA_W-1:0]       : '0;
    assign PC_curr     = w_head_valid ? w_head[C_ENT_W-1:DATA_W] : '0;
    assign PC_Next     = PC_curr + ADDR_W'(PC_INC);
    assign halted      = ~nHaltSig & (w_count == '0) & ~r_inflight_q;

    always_comb begin
        w_pc_d       = r_pc_q;
        w_inflight_d = imem_en;
        w_infl_pc_d  = r_pc_q;
        if (redirect) begin
            w_pc_d = PC_B;
        end else if (imem_en) begin
            w_pc_d = r_pc_q + ADDR_W'(PC_INC);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc_q       <= RESET_PC;
            r_inflight_q <= 1'b0;
            r_infl_pc_q  <= '0;
        end else begin
            r_pc_q       <= w_pc_d;
            r_inflight_q <= w_inflight_d;
            r_infl_pc_q  <= w_infl_pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH (C_ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({r_infl_pc_q, imem_data}),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .o_head      (w_head),
        .o_count     (w_count)
    );

endmodule : fetch_queue
`default_nettype wire
